umi_address_unremap: RTL
========================

Name: umi_address_unremap

Overview:
- Return-path companion to the UMI address remapper.
- Sits on the response channel, between the remapped fabric and the originating host.
- For response packets, rewrites the destination row/col ID field from the remapped ("new") ID back to the original ("old") ID, so responses reach the true requester.
- Registered, 2-entry elastic buffer with full valid/ready handshakes on both sides.

Parameters:
- CW, 32, UMI command width
- AW, 64, UMI address width
- DW, 256, UMI data width
- IDW, 16, row/col ID field width
- IDSB, 40, ID field start bit within dstaddr/srcaddr
- NMAPS, 8, number of ID map entries
- CNTW, 32, remap hit counter width

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- chipid  input  IDW  local chip ID (IDs equal to this are never unmapped)
- old_row_col_address  input  IDW*NMAPS  original IDs, entry i at [IDW*i +: IDW]
- new_row_col_address  input  IDW*NMAPS  remapped IDs, entry i at [IDW*i +: IDW]
- set_srcaddress_low  input  AW  offset-restore window low (inclusive)
- set_srcaddress_high  input  AW  offset-restore window high (inclusive)
- set_srcaddress_offset  input  AW  value added back to srcaddr
- umi_in_valid/cmd/dstaddr/srcaddr/data  input  1/CW/AW/AW/DW  incoming UMI packet
- umi_in_ready  output  1  buffer can accept
- umi_out_valid/cmd/dstaddr/srcaddr/data  output  1/CW/AW/AW/DW  unmapped packet
- umi_out_ready  input  1  downstream accepts
- remap_count  output  CNTW  number of packets whose dstaddr ID was rewritten

Behaviour:
- Single clock domain `clk`. Reset is asynchronous assert on `nreset` low, with synchronous deassert.
- Reset values:
  - umi_out_valid = 0, umi_in_ready = 1, remap_count = 0, buffer empty.
  - Output payload is 0.
- Transfer rule: a transfer occurs on a rising edge where valid & ready are both high.
  - Valid must not depend on ready.
  - Once umi_out_valid is asserted, the output payload is held stable until it is accepted.
- Response detect: cmd[0] == 0 and cmd[4:0] != 0. Request packets and cmd 0 pass through unmodified.
- ID lookup: id = dstaddr[IDSB +: IDW].
  - If id != chipid and id == new entry i, the ID field is replaced by old entry i.
  - Lowest matching i wins.
  - No match: pass through unchanged.
  - All other dstaddr bits, data, and cmd are untouched.
- Buffer: 2-entry FIFO with registered outputs.
  - umi_in_ready = (occupancy < 2), driven from a register.
  - Translation happens on the write side.
  - Latency from input transfer to umi_out_valid is 1 cycle.
  - Sustained throughput is 1 packet/cycle when umi_out_ready is held high.
- Boundary cases:
  - Push and pop in the same cycle: occupancy unchanged.
  - Full: umi_in_ready = 0; no drop and no overwrite.
  - Empty: umi_out_valid = 0.
  - Order is strictly preserved.
- remap_count increments by 1 on each input transfer whose ID was rewritten; it saturates at all-ones.
- Reset mid-operation: buffered packets are discarded, outputs return to their reset values, and the counter is cleared.
- The map and window inputs are quasi-static; changing them affects only packets accepted afterwards.

Optional Feature:
- Macro: UMI_UNREMAP_SRCOFFSET_EN
- Defined: for response packets whose srcaddr lies in [set_srcaddress_low, set_srcaddress_high], umi_out_srcaddr = srcaddr + set_srcaddress_offset.
  - Arithmetic is AW-bit modulo, with wrap permitted.
  - This undoes the forward path's offset subtraction.
- Undefined: srcaddr passes through unmodified, and the set_srcaddress_* ports are present but ignored.

Decomposition:
- Shared UMI package holds:
  - UMI opcode constants (UMI_REQ_*/UMI_RESP_*);
  - a response-detect function;
  - ID field helpers (IDSB/IDW slice).
- One natural sub-module: umi_unremap_lookup, a combinational priority matcher that takes id, chipid, and the map vectors and outputs a hit flag and the mapped ID.
- The FIFO and counter live in the top module.

Test Plan:
- Map entries are old = i, new = ~i; chipid = 16'h0004.
- Response mapping: cmd 0x04, dstaddr 0x00FF_FE00_0000_1000 → out dstaddr 0x0000_0100_0000_1000, 1 cycle later; remap_count = 1.
- Request pass-through: cmd 0x03 with ID 0xFFFE → output bit-identical to input; remap_count unchanged.
- Chipid and no-match: response with ID 0x0004 and response with ID 0x1234 → both unchanged.
- Backpressure: umi_out_ready = 0 while 3 packets are offered:
  - the first two are accepted, then umi_in_ready = 0;
  - after umi_out_ready = 1, all 3 emerge in order, none lost.
- Reset mid-stream: assert nreset with 2 packets buffered → umi_out_valid = 0 and umi_in_ready = 1 immediately; no stale packet after release.
- With UMI_UNREMAP_SRCOFFSET_EN, window 0x0600_0000_0000 to 0x06FF_FFFF_FFFF, offset 0x80:
  - response srcaddr 0x0000_0600_0000_0000 → 0x0000_0600_0000_0080;
  - srcaddr 0x0000_0700_0000_0000 → unchanged.

Source files
------------

// File: rtl/umi_address_unremap_pkg.sv
// umi_address_unremap_pkg: UMI opcodes, response detect and ID field defaults for the unremapper.
package umi_address_unremap_pkg;
  localparam int UMI_IDW = 16;
  localparam int UMI_IDSB = 40;
  localparam logic [4:0] UMI_REQ_READ = 5'h01;
  localparam logic [4:0] UMI_REQ_WRITE = 5'h03;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
  localparam logic [4:0] UMI_RESP_READ = 5'h02;
  localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
  function automatic logic is_resp(input logic [4:0] op);
    return ~op[0] & (op != 5'h00);
  endfunction
endpackage

// File: rtl/umi_address_unremap_lookup.sv
// umi_unremap_lookup: priority match of an ID against the new-ID table, lowest entry wins.
module umi_unremap_lookup #(
  parameter int IDW = 16,
  parameter int NMAPS = 8
) (
  input  logic [IDW-1:0]       id,
  input  logic [IDW-1:0]       chipid,
  input  logic [IDW*NMAPS-1:0] old_row_col_address,
  input  logic [IDW*NMAPS-1:0] new_row_col_address,
  output logic                 hit,
  output logic [IDW-1:0]       old_id
);
  always_comb begin
    hit = 1'b0;
    old_id = id;
    for (int i = NMAPS - 1; i >= 0; i--) begin
      if (id != chipid && id == new_row_col_address[IDW*i +: IDW]) begin
        hit = 1'b1;
        old_id = old_row_col_address[IDW*i +: IDW];
      end
    end
  end
endmodule

// File: rtl/umi_address_unremap.sv
// umi_address_unremap: restores original dstaddr IDs on responses through a 2-entry registered buffer.
// Define UMI_UNREMAP_SRCOFFSET_EN to add the srcaddr window offset back on responses.
module umi_address_unremap
  import umi_address_unremap_pkg::*;
#(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256,
  parameter int IDW = UMI_IDW,
  parameter int IDSB = UMI_IDSB,
  parameter int NMAPS = 8,
  parameter int CNTW = 32
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [IDW-1:0]       chipid,
  input  logic [IDW*NMAPS-1:0] old_row_col_address,
  input  logic [IDW*NMAPS-1:0] new_row_col_address,
  input  logic [AW-1:0]        set_srcaddress_low,
  input  logic [AW-1:0]        set_srcaddress_high,
  input  logic [AW-1:0]        set_srcaddress_offset,
  input  logic                 umi_in_valid,
  input  logic [CW-1:0]        umi_in_cmd,
  input  logic [AW-1:0]        umi_in_dstaddr,
  input  logic [AW-1:0]        umi_in_srcaddr,
  input  logic [DW-1:0]        umi_in_data,
  output logic                 umi_in_ready,
  output logic                 umi_out_valid,
  output logic [CW-1:0]        umi_out_cmd,
  output logic [AW-1:0]        umi_out_dstaddr,
  output logic [AW-1:0]        umi_out_srcaddr,
  output logic [DW-1:0]        umi_out_data,
  input  logic                 umi_out_ready,
  output logic [CNTW-1:0]      remap_count
);
  localparam int PW = CW + 2 * AW + DW;
  logic [IDW-1:0] in_id, mapped_id;
  logic hit, resp, remap, push, pop;
  logic [AW-1:0] dst_x, src_x;
  logic [PW-1:0] in_pkt, out_q, out_d, skid_q, skid_d;
  logic out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, in_rdy_q, in_rdy_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  assign in_id = umi_in_dstaddr[IDSB +: IDW];
  assign resp = is_resp(umi_in_cmd[4:0]);
  assign remap = resp & hit;
  umi_unremap_lookup #(.IDW(IDW), .NMAPS(NMAPS)) u_lookup (
    .id                  (in_id),
    .chipid              (chipid),
    .old_row_col_address (old_row_col_address),
    .new_row_col_address (new_row_col_address),
    .hit                 (hit),
    .old_id              (mapped_id)
  );
  always_comb begin
    dst_x = umi_in_dstaddr;
    dst_x[IDSB +: IDW] = remap ? mapped_id : in_id;
  end
`ifdef UMI_UNREMAP_SRCOFFSET_EN
  assign src_x = (resp && umi_in_srcaddr >= set_srcaddress_low && umi_in_srcaddr <= set_srcaddress_high)
               ? umi_in_srcaddr + set_srcaddress_offset : umi_in_srcaddr;
`else
  logic unused_src_window;
  assign unused_src_window = ^{set_srcaddress_low, set_srcaddress_high, set_srcaddress_offset};
  assign src_x = umi_in_srcaddr;
`endif
  assign in_pkt = {umi_in_cmd, dst_x, src_x, umi_in_data};
  assign push = umi_in_valid & in_rdy_q;
  assign pop = out_vld_q & umi_out_ready;
  // Head register feeds the output; the skid slot only fills when the head is stalled.
  always_comb begin
    out_d = (!out_vld_q || pop) ? (skid_vld_q ? skid_q : (push ? in_pkt : out_q)) : out_q;
    out_vld_d = (!out_vld_q || pop) ? (skid_vld_q | push) : 1'b1;
    skid_vld_d = (skid_vld_q & ~pop) | (push & out_vld_q & ~pop);
    skid_d = (push && out_vld_q && !pop) ? in_pkt : skid_q;
    in_rdy_d = ~(out_vld_d & skid_vld_d);
    cnt_d = (push && remap && !(&cnt_q)) ? cnt_q + CNTW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_q <= '0;
      skid_q <= '0;
      out_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      skid_q <= skid_d;
      out_vld_q <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q <= in_rdy_d;
      cnt_q <= cnt_d;
    end
  end
  assign {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = out_q;
  assign umi_out_valid = out_vld_q;
  assign umi_in_ready = in_rdy_q;
  assign remap_count = cnt_q;
endmodule
